// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide unit bus: operation request, busy flag,
// architectural HI/LO and the mfhi/mflo read-back path.
interface e_mdu_if;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    modport master (
        output Start, MDUOp, A, B,
        input  Busy, HI, LO, Result
    );

    modport slave (
        input  Start, MDUOp, A, B,
        output Busy, HI, LO, Result
    );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle mult/div unit holding HI/LO, busy for a fixed latency per op.
// Define MDU_DIV_EN to build the divider; otherwise div/divu act as no-ops.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave bus
);
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_t;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_t          state, state_next;
    logic [31:0]     hi_q, lo_q, hi_tmp, lo_tmp;
    logic [CW-1:0]   count;
    logic            start_long, commit, wr_hi, wr_lo;
    logic [CW-1:0]   long_cycles;
    logic [63:0]     long_res;
    logic [63:0]     prod_s, prod_u;

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

`ifdef MDU_DIV_EN
    // Signed divide is done on magnitudes so 0x80000000 / -1 needs no special case.
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, dvs_s, dvs_u, q_mag, r_mag, q_u, r_u;
    logic [63:0] div_s, div_u;

    assign a_neg  = bus.A[31];
    assign b_neg  = bus.B[31];
    assign b_zero = (bus.B == 32'd0);
    assign a_mag  = a_neg ? (~bus.A + 32'd1) : bus.A;
    assign b_mag  = b_neg ? (~bus.B + 32'd1) : bus.B;
    assign dvs_s  = b_zero ? 32'd1 : b_mag;
    assign dvs_u  = b_zero ? 32'd1 : bus.B;
    assign q_mag  = a_mag / dvs_s;
    assign r_mag  = a_mag % dvs_s;
    assign q_u    = bus.A / dvs_u;
    assign r_u    = bus.A % dvs_u;
    assign div_s  = b_zero ? {hi_q, lo_q}
                           : {(a_neg ? (~r_mag + 32'd1) : r_mag),
                              ((a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag)};
    assign div_u  = b_zero ? {hi_q, lo_q} : {r_u, q_u};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next  = state;
        start_long  = 1'b0;
        commit      = 1'b0;
        wr_hi       = 1'b0;
        wr_lo       = 1'b0;
        long_cycles = CW'(MULT_CYCLES);
        long_res    = prod_s;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOp)
                        OP_MULT:  start_long = 1'b1;
                        OP_MULTU: begin
                            start_long = 1'b1;
                            long_res   = prod_u;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV: begin
                            start_long  = 1'b1;
                            long_cycles = CW'(DIV_CYCLES);
                            long_res    = div_s;
                        end
                        OP_DIVU: begin
                            start_long  = 1'b1;
                            long_cycles = CW'(DIV_CYCLES);
                            long_res    = div_u;
                        end
`endif
                        OP_MTHI:  wr_hi = 1'b1;
                        OP_MTLO:  wr_lo = 1'b1;
                        default:  ;
                    endcase
                    if (start_long) state_next = RUN;
                end
            end
            RUN: begin
                // Counter reaches zero on this edge: commit and return to idle.
                if (count == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
            count  <= '0;
        end else begin
            if (start_long) begin
                hi_tmp <= long_res[63:32];
                lo_tmp <= long_res[31:0];
                count  <= long_cycles;
            end else if (state == RUN) begin
                count <= count - 1'b1;
            end
            if (commit) begin
                hi_q <= hi_tmp;
                lo_q <= lo_tmp;
            end
            if (wr_hi) hi_q <= bus.A;
            if (wr_lo) lo_q <= bus.A;
        end
    end

    assign bus.Busy   = (state == RUN);
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.Result = (bus.MDUOp == OP_MFHI) ? hi_q :
                        (bus.MDUOp == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: random and directed mult/div against a
// 64-bit arithmetic reference model of HI/LO. Honours MDU_DIV_EN.
module tb_e_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu_if bus ();

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = s;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    // Expected {HI,LO} after an op, using wide integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV:   if (b == 32'd0) return {m_hi, m_lo};
                      else return {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b == 32'd0) return {m_hi, m_lo};
                      else return {32'(ua % ub), 32'(ua / ub)};
            default:  return {m_hi, m_lo};
        endcase
    endfunction

    task automatic check_hilo(input string name);
        checks++;
        if ({bus.HI, bus.LO} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL %s hilo=%h expected=%h", name, {bus.HI, bus.LO}, {m_hi, m_lo});
        end
    endtask

    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int n, input string name);
        logic [63:0] exp_v;
        int          cyc;
        exp_v = model(op, a, b);
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, OP_NONE, $urandom, $urandom);
        cyc = 0;
        while (bus.Busy === 1'b1 && cyc < 200) begin
            check_hilo({name, "_old_during_busy"});
            step();
            drive(1'b0, OP_NONE, $urandom, $urandom);
            cyc++;
        end
        checks++;
        if (cyc != n) begin
            errors++;
            $display("FAIL %s_busy_len cycles=%0d expected=%0d", name, cyc, n);
        end
        {m_hi, m_lo} = exp_v;
        check_hilo(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        repeat (2) step();
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy busy=%b expected=0", bus.Busy);
        end
        check_hilo("reset_hilo");
        bus.MDUOp = OP_MFHI;
        #1;
        checks++;
        if (bus.Result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mfhi result=%h expected=0", bus.Result);
        end
        bus.MDUOp = OP_MFLO;
        #1;
        checks++;
        if (bus.Result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mflo result=%h expected=0", bus.Result);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mult_directed();
        run_long(OP_MULT, 32'hFFFF_FFFE, 32'd3, MULT_N, "mult_neg2x3");
        checks++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const hilo=%h expected=ffffffff_fffffffa", {bus.HI, bus.LO});
        end
        run_long(OP_MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N, "multu_directed");
        checks++;
        if ({bus.HI, bus.LO} !== 64'h0000_0002_FFFF_FFFA) begin
            errors++;
            $display("FAIL multu_const hilo=%h expected=00000002_fffffffa", {bus.HI, bus.LO});
        end
    endtask

    task automatic test_mt_and_result();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            drive(1'b1, OP_MTHI, v, $urandom);
            step();
            m_hi = v;
            v = $urandom;
            drive(1'b1, OP_MTLO, v, $urandom);
            step();
            m_lo = v;
            drive(1'b0, OP_NONE, $urandom, $urandom);
            check_hilo("mthi_mtlo");
        end
        // Result follows MDUOp combinationally and ignores Start.
        for (int op = 0; op < 16; op += 3) begin
            drive(op[0], 4'(op), $urandom, $urandom);
            #1;
            checks++;
            if (bus.Result !== ((op == 7) ? m_hi : (op == 8) ? m_lo : 32'd0)) begin
                errors++;
                $display("FAIL result_op%0d result=%h", op, bus.Result);
            end
        end
        drive(1'b1, OP_MFHI, $urandom, $urandom);
        #1;
        checks++;
        if (bus.Result !== m_hi) begin
            errors++;
            $display("FAIL result_mfhi result=%h expected=%h", bus.Result, m_hi);
        end
        step();
        drive(1'b1, OP_MFLO, $urandom, $urandom);
        #1;
        checks++;
        if (bus.Result !== m_lo) begin
            errors++;
            $display("FAIL result_mflo result=%h expected=%h", bus.Result, m_lo);
        end
        step();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        check_hilo("mf_no_side_effect");
    endtask

    task automatic test_mult_random();
        for (int i = 0; i < 8; i++)
            run_long((i % 2 == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom, MULT_N, "mult_random");
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, "div_neg7_2");
        checks++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_const hilo=%h expected=ffffffff_fffffffd", {bus.HI, bus.LO});
        end
        run_long(OP_DIVU, 32'd7, 32'd2, DIV_N, "divu_7_2");
        checks++;
        if ({bus.HI, bus.LO} !== 64'h0000_0001_0000_0003) begin
            errors++;
            $display("FAIL divu_const hilo=%h expected=00000001_00000003", {bus.HI, bus.LO});
        end
        run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, "div_overflow");
        checks++;
        if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin
            errors++;
            $display("FAIL div_overflow_const hilo=%h expected=00000000_80000000", {bus.HI, bus.LO});
        end
        drive(1'b1, OP_MTHI, 32'h11, 32'd0);
        step();
        drive(1'b1, OP_MTLO, 32'h22, 32'd0);
        step();
        m_hi = 32'h11;
        m_lo = 32'h22;
        run_long(OP_DIV, $urandom, 32'd0, DIV_N, "div_by_zero");
        run_long(OP_DIVU, $urandom, 32'd0, DIV_N, "divu_by_zero");
        checks++;
        if ({bus.HI, bus.LO} !== 64'h0000_0011_0000_0022) begin
            errors++;
            $display("FAIL div0_const hilo=%h expected=00000011_00000022", {bus.HI, bus.LO});
        end
        for (int i = 0; i < 8; i++)
            run_long((i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom,
                     (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31)), DIV_N, "div_random");
    endtask
`else
    task automatic test_div_disabled();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, (i == 0) ? OP_DIVU : OP_DIV, 32'd7, 32'd2);
            step();
            drive(1'b0, OP_NONE, 32'd0, 32'd0);
            checks++;
            if (bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL div_disabled_busy busy=%b expected=0", bus.Busy);
            end
            step();
            check_hilo("div_disabled_hilo");
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [63:0] exp_v;
        int          cyc;
        exp_v = model(OP_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        drive(1'b1, OP_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        step();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        step();
        // mthi held from the 2nd busy cycle through the falling edge of Busy.
        drive(1'b1, OP_MTHI, 32'hDEAD, 32'd0);
        cyc = 1;
        while (bus.Busy === 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != MULT_N) begin
            errors++;
            $display("FAIL b2b_busy_len cycles=%0d expected=%0d", cyc, MULT_N);
        end
        {m_hi, m_lo} = exp_v;
        check_hilo("b2b_start_ignored");
        step();
        m_hi = 32'hDEAD;
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        check_hilo("b2b_first_accept");
        run_long(OP_MULTU, $urandom, $urandom, MULT_N, "b2b_next_mult");
        run_long(OP_MULT, $urandom, $urandom, MULT_N, "b2b_back_to_back");
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, OP_MULT, $urandom, $urandom);
        step();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        step();
        #2;
        reset = 1'b1;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy busy=%b expected=0", bus.Busy);
        end
        check_hilo("reset_mid_hilo");
        step();
        reset = 1'b0;
        repeat (MULT_N + 2) step();
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after busy=%b expected=0", bus.Busy);
        end
        check_hilo("reset_mid_discarded");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult_directed();
        test_mt_and_result();
        test_mult_random();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit in the Execute stage, alongside the single-cycle ALU. It accepts a mult/div operation with its two operands and holds architectural HI/LO registers. It raises `Busy` for a fixed latency so the hazard unit can stall dependent `mfhi`/`mflo`/`mthi`/`mtlo` and later MDU ops, then commits the result to HI/LO. It serves the `mfhi`/`mflo` read path back into the pipeline.

## Interface
- `MULT_CYCLES`, 5, Busy duration for mult/multu (≥1)
- `DIV_CYCLES`, 10, Busy duration for div/divu (≥1)
- `clk` input 1 — single clock, rising edge
- `reset` input 1 — asynchronous, active-high; clears all state
- `Start` input 1 — qualifies `MDUOp` this cycle
- `MDUOp` input 4 — 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- `A` input 32 — rs operand
- `B` input 32 — rt operand
- `Busy` output 1 — long op in flight
- `HI` output 32 — architectural HI register
- `LO` output 32 — architectural LO register
- `Result` output 32 — combinational: HI when `MDUOp`=7, LO when 8, else 0 (independent of `Start`)

## Operation
- States: IDLE, RUN. Reset → IDLE; `Busy`=0, `HI`=`LO`=0, counter=0, temp regs=0.
- IDLE, `Start`=1:
  - ops 1–4: latch computed {hi,lo} into temp regs; load counter with the op's cycle count; → RUN.
  - op 5: HI←A. Op 6: LO←A. Both at the same edge; stay IDLE.
  - ops 0, 7–15: no state change.
- RUN: counter decrements every edge. At the edge where it reaches 0: HI/LO←temp; → IDLE.
- `Start` during RUN: ignored, whatever the op (incl. mthi/mtlo). The hazard unit guarantees none is issued.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0): temp←current HI/LO, so HI/LO are unchanged. Full `DIV_CYCLES` Busy still applies.
- Operands are sampled only at the Start edge. Later changes on A/B have no effect.

## Timing
- Start of a long op at edge E0: `Busy`=1 from just after E0 until just after E0+N (N = op cycle count), i.e. exactly N cycles high.
- HI/LO show new values just after E0+N. Before that they show the old values.
- Back-to-back: a new `Start` sampled at edge E0+N (Busy still 1 before that edge) is ignored. The first accepted restart is at E0+N+1.
- mthi/mtlo: one-cycle write; visible on `HI`/`LO` the cycle after the edge.
- `Result` has zero latency from `MDUOp` and current HI/LO. It is not forwarded from an in-flight op.
- `reset` asserted mid-RUN: immediate return to IDLE, `Busy`=0, HI=LO=0, in-flight result discarded.

## Configuration
- `MDU_DIV_EN` defined: div/divu behave as above.
- `MDU_DIV_EN` undefined:
  - No divider logic is compiled.
  - MDUOp 3/4 are treated as none: no Busy, HI/LO unchanged.
  - mult/multu/mthi/mtlo/mf* are unaffected.

## Test plan
- Reset, then check state → `Busy`=0, HI=LO=0, `Result`=0 for MDUOp 7/8. Assert `reset` mid-mult → Busy drops at once and HI/LO read 0.
- mult A=0xFFFFFFFE (−2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo, then div by B=0 → Busy 10 cycles; HI/LO stay 0x11/0x22.
- Issue mult, then Start with mthi A=0xDEAD at cycle 2 of Busy → ignored; HI/LO equal the mult result. A Start at the first cycle after Busy falls is accepted.
- With `MDU_DIV_EN` undefined: Start with divu → Busy stays 0 and HI/LO are unchanged. With it defined: div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
